bcd_addsub_serial: RTL and testbench
====================================

// Module: bcd_addsub_serial
// PURPOSE
//   Parametrised digit-serial BCD adder/subtractor with valid/ready handshakes.
//   Successor to the fixed 4-digit combinational BCD adder: N digits, add or subtract mode,
//   invalid-digit detection. Processes one BCD digit per clock, LSD first, reusing one
//   digit-adder cell. Sits between BCD operand sources (counters, keypad/display paths)
//   and BCD result consumers.
// PARAMETERS
//   NDIGITS  4  number of BCD digits per operand (>=1); operand/result width = 4*NDIGITS
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous, active-high reset
//   in_valid   in   1          operand set a/b/cin/sub is valid
//   in_ready   out  1          block can accept operands (high only in IDLE)
//   a          in   4*NDIGITS  BCD operand A, digit i at bits [4i+3:4i]
//   b          in   4*NDIGITS  BCD operand B
//   cin        in   1          add: carry-in; sub: borrow-in
//   sub        in   1          0 = a+b+cin; 1 = a-b-cin
//   out_valid  out  1          sum/cout/err valid; held until out_ready
//   out_ready  in   1          consumer accepts result
//   sum        out  4*NDIGITS  BCD result (sub: ten's complement when negative)
//   cout       out  1          add: decimal carry-out; sub: 1 = no borrow (a >= b+cin)
//   err        out  1          some digit of a or b was > 9
// BEHAVIOUR
//   - Reset (sync, rst=1 at clk edge): state IDLE; in_ready=1 after the edge;
//     out_valid=0, sum=0, cout=0, err=0, digit index=0. Reset mid-CALC/DONE discards the
//     operation silently; no partial result is ever flagged valid.
//   - FSM: IDLE -> CALC on in_valid&&in_ready (latch a, b, sub; carry reg = sub ? ~cin : cin;
//     idx=0; err=0).
//   - CALC: each cycle process digit idx:
//     - bd = sub ? 9-b[idx] : b[idx].
//     - t = a[idx] + bd + carry (5-bit).
//     - If t > 9: digit = t+6 (low 4 bits), carry=1; else digit = t, carry=0.
//     - Write digit into sum[idx]; err |= (a[idx]>9)|(b[idx]>9); idx++.
//   - CALC -> DONE after digit NDIGITS-1 is processed (NDIGITS cycles in CALC).
//   - DONE: out_valid=1; cout = final carry. If err=1, sum forced to 0 and cout=0.
//     Outputs stable while out_valid && !out_ready. DONE -> IDLE on out_ready.
//   - Latency: acceptance edge T; out_valid high after edge T+NDIGITS.
//     Throughput: one operation per NDIGITS+2 cycles.
//   - in_ready=0 in CALC and DONE; in_valid there is ignored, and the source must hold it.
//     out_ready while out_valid=0 is ignored.
//   - sub=1 result: a + (10^N-1-b) + ~cin, i.e. ten's complement. cout=0 means the result
//     is negative, with magnitude 10^N - sum.
//   - Wrap-around: add overflow beyond 10^N-1 gives sum mod 10^N, cout=1; no saturation.
//   - sum/cout/err registered; may change during CALC, meaningful only when out_valid=1.
// TESTING (NDIGITS=4 unless noted)
//   1. a=1823 b=2613 cin=1 sub=0 -> sum=4437 cout=0 err=0; out_valid exactly 4 cycles
//      after acceptance.
//   2. a=5872 b=6426 cin=1 sub=0 -> sum=2299 cout=1 (overflow wrap); also
//      a=9999 b=0000 cin=1 -> sum=0000 cout=1.
//   3. sub=1: a=5353 b=5158 cin=0 -> sum=0195 cout=1; a=4352 b=5613 cin=0 -> sum=8739 cout=0.
//   4. a=1A23 b=2613 -> err=1, sum=0000, cout=0; the next valid operation clears err.
//   5. Backpressure: hold out_ready=0 for 5 cycles -> sum/cout stable, in_ready=0, a new
//      in_valid is not accepted; release -> IDLE, then the next operation is accepted.
//   6. Assert rst in the 2nd CALC cycle -> next cycle out_valid=0, in_ready=1, sum=0.
//      Repeat tests 1 and 3 with NDIGITS=1 and NDIGITS=8 (random BCD vs integer model).

Source files
------------

// File: rtl/bcd_addsub_serial.sv
// bcd_addsub_serial: digit-serial BCD adder/subtractor, one digit per clock, LSD first,
// with valid/ready handshakes and invalid-digit detection.
module bcd_addsub_serial #(
   parameter int NDIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NDIGITS-1:0] a,
   input  logic [4*NDIGITS-1:0] b,
   input  logic                 cin,
   input  logic                 sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NDIGITS-1:0] sum,
   output logic                 cout,
   output logic                 err
);
   localparam int W  = 4 * NDIGITS;
   localparam int IW = NDIGITS > 1 ? $clog2(NDIGITS) : 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_n;
   logic [W-1:0] a_r, b_r;
   logic sub_r, carry, carry_n, last, bad;
   logic [IW-1:0] idx;
   logic [3:0] ad, bdr, bd, dig;
   logic [4:0] t;
   always_comb begin
      ad      = a_r[4*idx +: 4];
      bdr     = b_r[4*idx +: 4];
      bd      = sub_r ? 4'd9 - bdr : bdr;
      t       = 5'(ad) + 5'(bd) + 5'(carry);
      carry_n = t > 5'd9;
      dig     = carry_n ? 4'(t + 5'd6) : t[3:0];
      bad     = (ad > 4'd9) | (bdr > 4'd9);
      last    = idx == IW'(NDIGITS - 1);
   end
   always_comb begin
      state_n = state == IDLE ? (in_valid ? CALC : IDLE)
              : state == CALC ? (last ? DONE : CALC)
              : (out_ready ? IDLE : DONE);
   end
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r   <= '0;
         b_r   <= '0;
         sub_r <= 1'b0;
         carry <= 1'b0;
         idx   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         err   <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_r   <= a;
         b_r   <= b;
         sub_r <= sub;
         carry <= sub ? ~cin : cin;
         idx   <= '0;
         err   <= 1'b0;
      end else if (state == CALC) begin
         sum[4*idx +: 4] <= dig;
         carry <= carry_n;
         idx   <= idx + 1'b1;
         err   <= err | bad;
         // an invalid digit anywhere zeroes the whole result on the final step
         if (last) begin
            cout <= carry_n & ~(err | bad);
            if (err | bad) sum <= '0;
         end
      end
   end
endmodule

// File: tb/tb_bcd_addsub_serial.sv
// tb_bcd_addsub_serial: directed checks on 4-digit instance plus 1- and 8-digit
// instances checked against a decimal integer model.
module tb_bcd_addsub_serial;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic [31:0] a_bus = '0, b_bus = '0;
   logic cin = 1'b0, sub = 1'b0;
   logic [2:0] iv = '0, ordy = '0;
   wire ir4, ir1, ir8, ov4, ov1, ov8, c4, c1, c8, e4, e1, e8;
   wire [15:0] s4;
   wire [3:0]  s1;
   wire [31:0] s8;
   int checks = 0, errors = 0, lat = 0;

   bcd_addsub_serial #(.NDIGITS(4)) dut4 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir4),
      .a(a_bus[15:0]), .b(b_bus[15:0]), .cin(cin), .sub(sub), .out_valid(ov4), .out_ready(ordy[0]),
      .sum(s4), .cout(c4), .err(e4));
   bcd_addsub_serial #(.NDIGITS(1)) dut1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1),
      .a(a_bus[3:0]), .b(b_bus[3:0]), .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(ordy[1]),
      .sum(s1), .cout(c1), .err(e1));
   bcd_addsub_serial #(.NDIGITS(8)) dut8 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir8),
      .a(a_bus), .b(b_bus), .cin(cin), .sub(sub), .out_valid(ov8), .out_ready(ordy[2]),
      .sum(s8), .cout(c8), .err(e8));

   function automatic logic [31:0] osum(int sel);
      return sel == 0 ? {16'h0, s4} : sel == 1 ? {28'h0, s1} : s8;
   endfunction
   function automatic logic ocout(int sel);
      return sel == 0 ? c4 : sel == 1 ? c1 : c8;
   endfunction
   function automatic logic oerr(int sel);
      return sel == 0 ? e4 : sel == 1 ? e1 : e8;
   endfunction
   function automatic logic oov(int sel);
      return sel == 0 ? ov4 : sel == 1 ? ov1 : ov8;
   endfunction
   function automatic logic oir(int sel);
      return sel == 0 ? ir4 : sel == 1 ? ir1 : ir8;
   endfunction
   function automatic longint p10(int n);
      longint r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction
   function automatic logic [31:0] tobcd(longint v, int n);
      logic [31:0] r = '0;
      longint x = v;
      for (int i = 0; i < n; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask
   task automatic op(int sel, logic [31:0] av, logic [31:0] bv, logic c, logic s);
      @(negedge clk);
      a_bus = av; b_bus = bv; cin = c; sub = s; iv[sel] = 1'b1;
      @(negedge clk);
      iv[sel] = 1'b0;
      lat = 0;
      while (!oov(sel) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask
   task automatic drain(int sel);
      ordy[sel] = 1'b1;
      @(negedge clk);
      ordy[sel] = 1'b0;
   endtask
   task automatic expect_res(string tag, int sel, logic [31:0] es, logic ec, logic ee, int el);
      chk({tag, "_lat"}, 64'(lat), 64'(el));
      chk({tag, "_sum"}, 64'(osum(sel)), 64'(es));
      chk({tag, "_cout"}, 64'(ocout(sel)), 64'(ec));
      chk({tag, "_err"}, 64'(oerr(sel)), 64'(ee));
   endtask

   initial begin
      longint m, av, bv, r;
      logic c, s;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("rst_in_ready", 64'(oir(k)), 64'd1);
         chk("rst_out_valid", 64'(oov(k)), 64'd0);
         chk("rst_sum", 64'(osum(k)), 64'd0);
         chk("rst_cout_err", 64'({ocout(k), oerr(k)}), 64'd0);
      end
      op(0, 32'h1823, 32'h2613, 1'b1, 1'b0); expect_res("t1", 0, 32'h4437, 1'b0, 1'b0, 4); drain(0);
      op(0, 32'h5872, 32'h6426, 1'b1, 1'b0); expect_res("t2a", 0, 32'h2299, 1'b1, 1'b0, 4); drain(0);
      op(0, 32'h9999, 32'h0000, 1'b1, 1'b0); expect_res("t2b", 0, 32'h0000, 1'b1, 1'b0, 4); drain(0);
      op(0, 32'h5353, 32'h5158, 1'b0, 1'b1); expect_res("t3a", 0, 32'h0195, 1'b1, 1'b0, 4); drain(0);
      op(0, 32'h4352, 32'h5613, 1'b0, 1'b1); expect_res("t3b", 0, 32'h8739, 1'b0, 1'b0, 4); drain(0);
      op(0, 32'h1A23, 32'h2613, 1'b0, 1'b0); expect_res("t4err", 0, 32'h0000, 1'b0, 1'b1, 4); drain(0);
      op(0, 32'h1823, 32'h2613, 1'b1, 1'b0); expect_res("t4clr", 0, 32'h4437, 1'b0, 1'b0, 4);
      // hold the result under backpressure while a new operand is offered
      for (int i = 0; i < 5; i++) begin
         a_bus = 32'h0001; b_bus = 32'h0001; cin = 1'b0; sub = 1'b0; iv[0] = 1'b1;
         @(negedge clk);
         chk("bp_sum", 64'(s4), 64'h4437);
         chk("bp_cout", 64'(c4), 64'd0);
         chk("bp_valid_ready", 64'({ov4, ir4}), 64'b10);
      end
      iv[0] = 1'b0;
      drain(0);
      chk("bp_idle", 64'({ov4, ir4}), 64'b01);
      op(0, 32'h0001, 32'h0001, 1'b0, 1'b0); expect_res("bp_next", 0, 32'h0002, 1'b0, 1'b0, 4); drain(0);
      @(negedge clk);
      a_bus = 32'h1823; b_bus = 32'h2613; cin = 1'b1; sub = 1'b0; iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_valid", 64'(ov4), 64'd0);
      chk("rst_mid_ready", 64'(ir4), 64'd1);
      chk("rst_mid_sum", 64'(s4), 64'd0);
      op(1, 32'h9, 32'h9, 1'b1, 1'b0); expect_res("n1_add", 1, 32'h9, 1'b1, 1'b0, 1); drain(1);
      op(1, 32'h3, 32'h7, 1'b0, 1'b1); expect_res("n1_sub", 1, 32'h6, 1'b0, 1'b0, 1); drain(1);
      op(2, 32'h99999999, 32'h0, 1'b1, 1'b0); expect_res("n8_wrap", 2, 32'h0, 1'b1, 1'b0, 8); drain(2);
      for (int sel = 1; sel < 3; sel++) begin
         m = p10(sel == 1 ? 1 : 8);
         for (int k = 0; k < 6; k++) begin
            av = longint'($urandom_range(32'(m - 1), 0));
            bv = longint'($urandom_range(32'(m - 1), 0));
            c = 1'($urandom_range(1, 0));
            s = k[0];
            r = s ? av + (m - 1 - bv) + (c ? 0 : 1) : av + bv + (c ? 1 : 0);
            op(sel, tobcd(av, 8), tobcd(bv, 8), c, s);
            expect_res(sel == 1 ? "n1_rand" : "n8_rand", sel, tobcd(r % m, 8), r >= m, 1'b0,
                       sel == 1 ? 1 : 8);
            drain(sel);
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
